// File: rtl/serial_sub_pkg.sv
// ----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor:
//   - DEFAULT_WIDTH : default operand/result width
//   - state_e       : controller states (IDLE, RUN, DONE)
// ----------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : serial_sub_pkg

// File: rtl/serial_sub_full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
// One-bit combinational subtractor stage: computes x - y - bin.
// Ports:
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow into this bit
//   d    : difference bit
//   bout : borrow out of this bit
// ----------------------------------------------------------------------------
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when the subtrahend side (y + bin) exceeds x; the last term
    // covers y=1 with x and bin equal.
    assign bout = (~x & y) | (~x & bin) | (y & ~(x ^ bin));

endmodule : full_subtractor

// File: rtl/serial_sub.sv
// ----------------------------------------------------------------------------
// serial_sub
// Bit-serial subtractor: computes (a - b - bin) mod 2^WIDTH one bit per clock,
// LSB first, using a single full_subtractor stage and a running borrow.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset
//   start : request, accepted only in IDLE or DONE
//   a     : minuend, captured on accepted start
//   b     : subtrahend, captured on accepted start
//   bin   : borrow-in, captured on accepted start
//   busy  : high while the operation is running
//   done  : one-cycle pulse, diff/bout hold the new result
//   diff  : difference, (a - b - bin) mod 2^WIDTH
//   bout  : borrow-out, 1 iff a < b + bin (unsigned)
// ----------------------------------------------------------------------------
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // One extra bit so the counter can reach WIDTH without wrapping.
    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               br_q, br_d;
    logic               bout_q, bout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               stage_d;
    logic               stage_bout;

    // Operand registers shift right, so bit 0 is always the current bit.
    full_subtractor u_fs (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (br_q),
        .d    (stage_d),
        .bout (stage_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = stage_bout;
                // New bit enters at the MSB; after WIDTH shifts the first
                // bit computed sits at bit 0.
                res_d = {stage_d, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_BIT) begin
                    // Publish only the complete result so diff/bout never
                    // expose a partially shifted value.
                    diff_d  = {stage_d, res_q[WIDTH-1:1]};
                    bout_d  = stage_bout;
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule : serial_sub
